aes_dec_scheduler: RTL and testbench

//  Sequencer for the 11-stage pipelined AES-128 decryption core.
//  - Loads a new key and runs the core's key-expansion FSM until all round keys are registered.
//  - Admits ciphertext blocks into the core via a valid/ready handshake.
//  - Tracks in-flight blocks; flags plaintext at the output with m_valid.
//  - Drains the pipeline before any rekey, so no block is decrypted with mixed keys.

---
 rtl/aes_dec_pkg.sv | 16 +
 rtl/aes_dec_scheduler_valid_pipe.sv | 56 +++++
 rtl/aes_dec_scheduler.sv | 150 +++++++++++++++
 tb/tb_aes_dec_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decryption scheduler.
// Optional per-block tag tracking is enabled with the AES_DEC_TAG_EN macro.
package aes_dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam int         AES_LATENCY    = 11;
   localparam logic [3:0] AES_ROUND_DONE = 4'd11;
   localparam int         AES_TAG_W      = 4;

endpackage

// File: rtl/aes_dec_scheduler_valid_pipe.sv
// aes_valid_pipe: shift register tracking which pipeline stages of the
// decryption core hold a real block. With AES_DEC_TAG_EN defined, a tag
// travels alongside each valid bit and is forced to 0 on idle cycles.
module aes_valid_pipe
   import aes_dec_pkg::*;
#(
   parameter int DEPTH = AES_LATENCY
`ifdef AES_DEC_TAG_EN
   ,
   parameter int TAG_W = AES_TAG_W
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
`ifdef AES_DEC_TAG_EN
   input  logic [TAG_W-1:0] i_tag,
   output logic [TAG_W-1:0] o_tag,
`endif
   output logic             o_valid
);

   logic [DEPTH-1:0] r_vpipe;

   // Shift the valid bit one stage per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vpipe <= '0;
      end else begin
         r_vpipe <= {r_vpipe[DEPTH-2:0], i_valid};
      end
   end

   assign o_valid = r_vpipe[DEPTH-1];

`ifdef AES_DEC_TAG_EN
   logic [TAG_W-1:0] r_tag [DEPTH];

   // Tags move in lockstep with the valid bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign o_tag = o_valid ? r_tag[DEPTH-1] : '0;
`endif

endmodule

// File: rtl/aes_dec_scheduler.sv
// aes_dec_scheduler: sequences key expansion and block admission for the
// 11-stage pipelined AES-128 decryption core, draining in-flight blocks
// before every rekey. Define AES_DEC_TAG_EN to add the s_tag/m_tag ports.
//
//  state  | meaning
//  IDLE   | no valid key; wait for key_req
//  EXPAND | core key FSM running (core_fsm_en=1), no admission
//  RUN    | round keys valid, blocks admitted while key_req is low
//  DRAIN  | rekey pending; wait for in-flight blocks to leave the core
module aes_dec_scheduler
   import aes_dec_pkg::*;
#(
   parameter int         LATENCY    = AES_LATENCY,
   parameter logic [3:0] ROUND_DONE = AES_ROUND_DONE
`ifdef AES_DEC_TAG_EN
   ,
   parameter int         TAG_W      = AES_TAG_W
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_req,
   output logic             key_ack,
   input  logic             s_valid,
   output logic             s_ready,
`ifdef AES_DEC_TAG_EN
   input  logic [TAG_W-1:0] s_tag,
`endif
   output logic             core_fsm_en,
   output logic             core_enable,
   input  logic [3:0]       core_round_cnt,
   output logic             m_valid,
`ifdef AES_DEC_TAG_EN
   output logic [TAG_W-1:0] m_tag,
`endif
   output logic             key_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_m_valid;
   logic             w_key_ack;
   logic             w_s_ready;
   logic             w_fsm_en;
   logic             w_key_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-state outputs; key_req beats s_valid in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_key_ack   = 1'b0;
      w_s_ready   = 1'b0;
      w_fsm_en    = 1'b0;
      w_key_ready = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_req) begin
               w_key_ack   = 1'b1;
               w_state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            w_fsm_en = 1'b1;
            if (core_round_cnt == ROUND_DONE) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_fsm_en    = 1'b1;
            w_key_ready = 1'b1;
            w_s_ready   = ~key_req;
            if (key_req) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // fsm_en stays low here so the core key FSM restarts at round 0.
            if (r_cnt == '0) begin
               if (key_req) begin
                  w_key_ack   = 1'b1;
                  w_state_nxt = EXPAND;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept = s_valid & w_s_ready;

   aes_valid_pipe #(
      .DEPTH (LATENCY)
`ifdef AES_DEC_TAG_EN
      ,
      .TAG_W (TAG_W)
`endif
   ) u_valid_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_accept),
`ifdef AES_DEC_TAG_EN
      .i_tag   (s_tag),
      .o_tag   (m_tag),
`endif
      .o_valid (w_m_valid)
   );

   // In-flight count: up on accept, down as the block leaves the core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         case ({w_accept, w_m_valid})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   a_cnt_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(w_m_valid && !w_accept && (r_cnt == '0)));
   a_cnt_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (r_cnt <= CNT_W'(LATENCY)));

   // key_ack is gated so it reads 0 the instant reset asserts.
   assign key_ack     = w_key_ack & ~rst;
   assign s_ready     = w_s_ready;
   assign core_fsm_en = w_fsm_en;
   assign core_enable = w_accept;
   assign m_valid     = w_m_valid;
   assign key_ready   = w_key_ready;
   assign busy        = (r_cnt != '0);

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Testbench for aes_dec_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the scheduler. Honors AES_DEC_TAG_EN.
module tb_aes_dec_scheduler;

   localparam int LAT = 11;
   localparam int M_IDLE = 0, M_EXPAND = 1, M_RUN = 2, M_DRAIN = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_req = 1'b0;
   logic       s_valid = 1'b0;
   logic [3:0] core_round_cnt = 4'd0;
   logic       key_ack, s_ready, core_fsm_en, core_enable, m_valid, key_ready, busy;
   logic [3:0] s_tag = 4'd0;
`ifdef AES_DEC_TAG_EN
   logic [3:0] m_tag;
`endif

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aes_dec_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .key_req        (key_req),
      .key_ack        (key_ack),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
`ifdef AES_DEC_TAG_EN
      .s_tag          (s_tag),
`endif
      .core_fsm_en    (core_fsm_en),
      .core_enable    (core_enable),
      .core_round_cnt (core_round_cnt),
      .m_valid        (m_valid),
`ifdef AES_DEC_TAG_EN
      .m_tag          (m_tag),
`endif
      .key_ready      (key_ready),
      .busy           (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out at t=%0t", nm, $time);
   endtask

   // Core key-FSM stand-in: round counter clears while fsm_en is low,
   // otherwise counts up to 11 and holds.
   initial begin
      logic fen;
      forever begin
         @(negedge clk);
         fen = core_fsm_en;
         @(posedge clk);
         #1;
         if (rst || !fen) core_round_cnt = 4'd0;
         else if (core_round_cnt < 4'd11) core_round_cnt = core_round_cnt + 4'd1;
      end
   end

   // Reference model: scheduler mode plus a queue of in-flight blocks,
   // each with the cycle number in which it must appear at the output.
   typedef struct {
      int         due;
      logic [3:0] tag;
   } blk_t;

   blk_t q[$];
   int   mode = M_IDLE;
   int   cyc = 0;

   always @(negedge clk) begin
      logic       e_sr, e_ce, e_mv, e_ack;
      logic [3:0] e_tag;
      int         infl;
      if (rst) begin
         chk("rst_key_ack", key_ack, 0);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_fsm_en", core_fsm_en, 0);
         chk("rst_core_enable", core_enable, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_key_ready", key_ready, 0);
         chk("rst_busy", busy, 0);
`ifdef AES_DEC_TAG_EN
         chk("rst_m_tag", m_tag, 0);
`endif
         q.delete();
         mode = M_IDLE;
      end else begin
         infl  = q.size();
         e_sr  = (mode == M_RUN) && !key_req;
         e_ce  = e_sr && s_valid;
         e_mv  = (infl != 0) && (q[0].due == cyc);
         e_tag = e_mv ? q[0].tag : 4'd0;
         e_ack = key_req && ((mode == M_IDLE) || (mode == M_DRAIN && infl == 0));
         chk("key_ack", key_ack, e_ack);
         chk("s_ready", s_ready, e_sr);
         chk("core_enable", core_enable, e_ce);
         chk("core_fsm_en", core_fsm_en, (mode == M_EXPAND) || (mode == M_RUN));
         chk("key_ready", key_ready, mode == M_RUN);
         chk("m_valid", m_valid, e_mv);
         chk("busy", busy, infl != 0);
`ifdef AES_DEC_TAG_EN
         chk("m_tag", m_tag, e_tag);
`endif
         if (e_mv) void'(q.pop_front());
         if (e_ce) q.push_back('{due: cyc + LAT, tag: s_tag});
         case (mode)
            M_IDLE:   if (key_req) mode = M_EXPAND;
            M_EXPAND: if (core_round_cnt == 4'd11) mode = M_RUN;
            M_RUN:    if (key_req) mode = M_DRAIN;
            default:  if (infl == 0) mode = key_req ? M_EXPAND : M_RUN;
         endcase
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request a key, drop key_req after key_ack, return cycles from ack to key_ready.
   task automatic rekey(output int lat);
      int n;
      bit acked;
      lat = -1; n = 0; acked = 0;
      tick();
      key_req = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (acked) begin
            n++;
            if (key_ready) begin
               lat = n;
               break;
            end
         end else if (key_ack) begin
            acked = 1;
         end
         tick();
         if (acked) key_req = 1'b0;
      end
      if (lat < 0) timeout("rekey");
   endtask

   task automatic rst_pulse(input string nm);
      int mv;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk({nm, "_key_ack"}, key_ack, 0);
      chk({nm, "_fsm_en"}, core_fsm_en, 0);
      chk({nm, "_m_valid"}, m_valid, 0);
      chk({nm, "_key_ready"}, key_ready, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_s_ready"}, s_ready, 0);
      key_req = 1'b0;
      s_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      mv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid || key_ready) mv++;
      end
      chk({nm, "_quiet_after"}, mv, 0);
   endtask

   initial begin
      int lat, mv_cnt, mv_first, mv_last, b_cnt, b_first, ack_c;
      bit acked, ack_seen;
`ifdef AES_DEC_TAG_EN
      logic [3:0] tags[$];
`endif

      // Reset values.
      repeat (3) @(posedge clk);
      #2;
      chk("reset_key_ack", key_ack, 0);
      chk("reset_key_ready", key_ready, 0);
      chk("reset_busy", busy, 0);
      tick();
      rst = 1'b0;

      // Key load: key_ready rises 13 cycles after key_ack.
      rekey(lat);
      chk("t1_ack_to_ready", lat, 13);

      // Single block.
      mv_cnt = 0; mv_first = -1; b_cnt = 0; b_first = -1;
      for (int c = 0; c <= 20; c++) begin
         tick();
         s_valid = (c == 0);
         @(negedge clk);
         if (c == 0) chk("t2_core_enable", core_enable, 1);
         if (m_valid) begin mv_cnt++; if (mv_first < 0) mv_first = c; end
         if (busy) begin b_cnt++; if (b_first < 0) b_first = c; end
      end
      chk("t2_mv_count", mv_cnt, 1);
      chk("t2_mv_cycle", mv_first, 11);
      chk("t2_busy_count", b_cnt, 11);
      chk("t2_busy_first", b_first, 1);

      // 20 back-to-back blocks.
      mv_cnt = 0; mv_first = -1; mv_last = -1; b_cnt = 0;
      for (int c = 0; c <= 40; c++) begin
         tick();
         s_valid = (c < 20);
         @(negedge clk);
         if (m_valid) begin mv_cnt++; if (mv_first < 0) mv_first = c; mv_last = c; end
         if (busy) b_cnt++;
      end
      chk("t3_mv_count", mv_cnt, 20);
      chk("t3_mv_first", mv_first, 11);
      chk("t3_mv_last", mv_last, 30);
      chk("t3_busy_count", b_cnt, 30);

      // Rekey with 5 blocks in flight; key_req collides with s_valid at cycle 5.
      mv_cnt = 0; ack_c = -1; acked = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         s_valid = (c <= 5);
         key_req = (c >= 5) && !acked;
         @(negedge clk);
         if (c == 5) begin
            chk("t4_s_ready", s_ready, 0);
            chk("t4_core_enable", core_enable, 0);
         end
         if (m_valid) mv_cnt++;
         if (key_ack && !acked) begin acked = 1; ack_c = c; end
      end
      chk("t4_mv_count", mv_cnt, 5);
      chk("t4_ack_cycle", ack_c, 16);
      chk("t4_key_ready", key_ready, 1);

      // key_req and s_valid in the same RUN cycle with nothing in flight.
      tick();
      key_req = 1'b1;
      s_valid = 1'b1;
      @(negedge clk);
      chk("t5_core_enable", core_enable, 0);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("t5_key_ready", key_ready, 0);
      chk("t5_key_ack", key_ack, 1);
      tick();
      key_req = 1'b0;
      ack_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (key_ready) begin ack_seen = 1; break; end
      end
      if (!ack_seen) timeout("t5_ready");

`ifdef AES_DEC_TAG_EN
      // Tags 1,2,3 emerge in order.
      for (int c = 0; c <= 20; c++) begin
         tick();
         s_valid = (c < 3);
         s_tag   = (c < 3) ? 4'(c + 1) : 4'd0;
         @(negedge clk);
         if (m_valid) tags.push_back(m_tag);
      end
      chk("tag_count", tags.size(), 3);
      if (tags.size() == 3) begin
         chk("tag_0", tags[0], 1);
         chk("tag_1", tags[1], 2);
         chk("tag_2", tags[2], 3);
      end
`endif

      // Reset with 3 blocks in flight.
      for (int c = 0; c < 5; c++) begin
         tick();
         s_valid = (c < 3);
         s_tag   = 4'(c + 1);
      end
      rst_pulse("t6_inflight");

      // Reset mid-expansion.
      tick();
      key_req = 1'b1;
      ack_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (key_ack) begin ack_seen = 1; break; end
      end
      if (!ack_seen) timeout("t6_ack");
      tick();
      key_req = 1'b0;
      repeat (4) tick();
      rst_pulse("t6_expand");

      // Randomized traffic with random rekeys and abandoned requests.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         acked = key_ack;
         tick();
         if (key_req) key_req = acked ? 1'b0 : ($urandom_range(0, 99) >= 4);
         else         key_req = ($urandom_range(0, 99) < 3);
         s_valid = ($urandom_range(0, 99) < 65);
         s_tag   = 4'($urandom);
      end
      tick();
      key_req = 1'b0;
      s_valid = 1'b0;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected end before", $time);
      $fatal(1, "watchdog");
   end

endmodule
